// File: rtl/fpu_wb_buffer.sv
// Writeback buffer behind the 3-cycle FP adder.
// The adder cannot stall, so every result it emits is captured in a small FIFO
// and drained to the FP register-file write port under a valid/ready handshake.
// Issue credits (issue_ok) keep the number of buffered plus in-flight results
// within DEPTH.
// Optional feature: define FPU_WB_BYPASS_EN to forward an adder result straight
// to the write port when the FIFO is empty.
module fpu_wb_buffer #(
  parameter int DEPTH    = 4,
  parameter int PIPE_LAT = 3
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     issue_req,
  output logic                     issue_ok,
  input  logic                     in_flag,
  input  logic [4:0]               in_addr,
  input  logic [31:0]              in_data,
  output logic                     wb_valid,
  input  logic                     wb_ready,
  output logic [4:0]               wb_addr,
  output logic [31:0]              wb_data,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     ovf_err
);

  // state | meaning
  // HOLD  | after reset; adder pipeline still holds stale results, ignore in_flag, no credits
  // RUN   | normal operation; terminal until reset

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int HW = $clog2(PIPE_LAT + 2);
  localparam int SW = CW + HW;

  typedef enum logic {HOLD = 1'b0, RUN = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [HW-1:0] hold_cnt, hold_cnt_nxt;
  logic          run;

  logic [36:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [HW-1:0] inflight;
  logic [4:0]    last_addr;
  logic [31:0]   last_data;

  logic          empty, full, arrive, push_req, push, pop;
  logic [36:0]   head, wb_word;
  logic [SW-1:0] credit_sum;

  // Holdoff state register and countdown.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= HOLD;
      hold_cnt <= HW'(PIPE_LAT);
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
    end
  end

  // Holdoff next-state: leave HOLD on the cycle the countdown reaches zero.
  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    case (state)
      HOLD: begin
        if (hold_cnt <= HW'(1)) begin
          hold_cnt_nxt = '0;
          state_nxt    = RUN;
        end else begin
          hold_cnt_nxt = hold_cnt - HW'(1);
        end
      end
      RUN:     state_nxt = RUN;
      default: state_nxt = HOLD;
    endcase
  end

  assign run    = (state == RUN);
  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign arrive = in_flag & run;

`ifdef FPU_WB_BYPASS_EN
  // Empty FIFO in RUN: present the adder result directly; it only needs
  // buffering if the register file does not take it this cycle.
  assign wb_valid = !empty | (run & in_flag);
  assign head     = empty ? {in_addr, in_data} : mem[rd_ptr];
  assign push_req = arrive & !(run & empty & wb_ready);
`else
  assign wb_valid = !empty;
  assign head     = mem[rd_ptr];
  assign push_req = arrive;
`endif

  assign pop  = wb_valid & wb_ready & !empty;
  assign push = push_req & (!full | pop);

  // While idle the write port shows the last word it presented.
  assign wb_word   = wb_valid ? head : {last_addr, last_data};
  assign wb_addr   = wb_word[36:32];
  assign wb_data   = wb_word[31:0];
  assign occupancy = count;

  assign credit_sum = SW'(count) + SW'(inflight);
  assign issue_ok   = run & (credit_sum < SW'(DEPTH));

  // FIFO storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_addr, in_data};
  end

  // Pointers, count, sticky overflow and last presented word.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      ovf_err   <= 1'b0;
      last_addr <= '0;
      last_data <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push_req && full && !pop) ovf_err <= 1'b1;
      if (wb_valid) begin
        last_addr <= wb_addr;
        last_data <= wb_data;
      end
    end
  end

  // In-flight op counter, saturating at 0 and PIPE_LAT.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      inflight <= '0;
    end else if (issue_req && !arrive && inflight != HW'(PIPE_LAT)) begin
      inflight <= inflight + HW'(1);
    end else if (arrive && !issue_req && inflight != '0) begin
      inflight <= inflight - HW'(1);
    end
  end

endmodule

// File: tb/tb_fpu_wb_buffer.sv
// Self-checking bench for fpu_wb_buffer: directed steps followed by a random
// phase, all checked against a queue-based reference model.
module tb_fpu_wb_buffer;
  localparam int DEPTH    = 4;
  localparam int PIPE_LAT = 3;

  logic        clk = 1'b0;
  logic        rstn;
  logic        issue_req, issue_ok;
  logic        in_flag;
  logic [4:0]  in_addr;
  logic [31:0] in_data;
  logic        wb_valid, wb_ready;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [$clog2(DEPTH):0] occupancy;
  logic        ovf_err;

  int tests  = 0;
  int failed = 0;

  // reference model state
  logic [36:0] q[$];
  int          infl;
  bit          ovf;
  int          since;
  logic [36:0] last;

  always #5 clk = ~clk;

  fpu_wb_buffer #(.DEPTH(DEPTH), .PIPE_LAT(PIPE_LAT)) dut (
    .clk(clk), .rstn(rstn), .issue_req(issue_req), .issue_ok(issue_ok),
    .in_flag(in_flag), .in_addr(in_addr), .in_data(in_data),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .occupancy(occupancy), .ovf_err(ovf_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    infl  = 0;
    ovf   = 0;
    since = 0;
    last  = '0;
  endtask

  // What the write port should show right now, from the model and current inputs.
  task automatic model_port(output bit vld, output logic [36:0] word);
    bit run;
    run  = (since >= PIPE_LAT);
    vld  = (q.size() > 0);
    word = last;
`ifdef FPU_WB_BYPASS_EN
    if (q.size() == 0 && run && in_flag) begin
      vld  = 1'b1;
      word = {in_addr, in_data};
    end
`endif
    if (q.size() > 0) word = q[0];
  endtask

  task automatic check_outputs();
    bit          vld;
    logic [36:0] word;
    bit          run;
    run = (since >= PIPE_LAT);
    model_port(vld, word);
    chk("wb_valid",  wb_valid, vld);
    chk("wb_addr",   wb_addr, word[36:32]);
    chk("wb_data",   wb_data, word[31:0]);
    chk("occupancy", occupancy, q.size());
    chk("ovf_err",   ovf_err, ovf);
    chk("issue_ok",  issue_ok, run && (q.size() + infl < DEPTH));
  endtask

  task automatic model_step();
    bit          vld, run, arrive, want;
    logic [36:0] word;
    int          cnt;
    cnt    = q.size();
    run    = (since >= PIPE_LAT);
    model_port(vld, word);
    arrive = in_flag && run;
    want   = arrive;
`ifdef FPU_WB_BYPASS_EN
    if (cnt == 0 && wb_ready) want = 1'b0;
`endif
    if (vld && wb_ready && cnt > 0) void'(q.pop_front());
    if (want) begin
      if (q.size() < DEPTH) q.push_back({in_addr, in_data});
      else ovf = 1'b1;
    end
    if (issue_req && !arrive && infl < PIPE_LAT) infl++;
    else if (arrive && !issue_req && infl > 0) infl--;
    if (vld) last = word;
    since++;
  endtask

  task automatic cycle();
    #1;
    check_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drv(input logic f, input logic [4:0] a, input logic [31:0] d,
                     input logic r, input logic iss);
    in_flag   = f;
    in_addr   = a;
    in_data   = d;
    wb_ready  = r;
    issue_req = iss;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    drv(0, 0, 0, 0, 0);
    do_reset();

    // holdoff: stale adder results ignored, credit appears at cycle PIPE_LAT
    drv(1, 7, 32'hDEAD_0007, 1, 0);
    cycle(); cycle(); cycle();
    drv(0, 0, 0, 1, 0);
    chk("hold_occ", occupancy, 0);
    chk("hold_issue_ok", issue_ok, 1);

    // single op
    drv(1, 5, 32'h3F80_0000, 1, 0);
    cycle();
    drv(0, 0, 0, 1, 0);
    cycle();
    chk("single_occ", occupancy, 0);
    cycle();

    // backpressure fill, then in-order drain
    for (int i = 1; i <= 4; i++) begin
      drv(1, 5'(i), $urandom, 0, 0);
      cycle();
    end
    drv(0, 0, 0, 0, 0);
    chk("fill_occ", occupancy, 4);
    chk("fill_issue_ok", issue_ok, 0);
    cycle();
    drv(0, 0, 0, 1, 0);
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk("drain_order", wb_addr, i);
      cycle();
    end
    cycle();

    // credit accounting with one buffered entry
    drv(1, 11, $urandom, 0, 0);
    cycle();
    drv(0, 0, 0, 0, 1);
    cycle(); cycle(); cycle();
    drv(0, 0, 0, 0, 0);
    chk("credit_after3", issue_ok, 0);
    cycle(); cycle();
    chk("credit_held", issue_ok, 0);
    drv(0, 0, 0, 1, 0);
    cycle();
    chk("credit_after_pop", issue_ok, 1);
    for (int i = 0; i < 3; i++) begin
      drv(1, 5'(12 + i), $urandom, 1, 0);
      cycle();
    end
    drv(0, 0, 0, 1, 0);
    cycle(); cycle();

    // simultaneous push and pop while full
    for (int i = 1; i <= 4; i++) begin
      drv(1, 5'(i), $urandom, 0, 0);
      cycle();
    end
    drv(1, 20, 32'h0000_0020, 1, 0);
    cycle();
    drv(0, 0, 0, 0, 0);
    chk("full_pp_occ", occupancy, 4);
    chk("full_pp_ovf", ovf_err, 0);
    cycle();
    drv(0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("full_pp_order", wb_addr, (i == 3) ? 20 : i + 2);
      cycle();
    end
    cycle();

    // overflow
    for (int i = 21; i <= 24; i++) begin
      drv(1, 5'(i), $urandom, 0, 0);
      cycle();
    end
    drv(1, 9, 32'h0000_0009, 0, 0);
    cycle();
    drv(0, 0, 0, 0, 0);
    chk("ovf_set", ovf_err, 1);
    chk("ovf_occ", occupancy, 4);
    cycle();
    drv(0, 0, 0, 1, 0);
    for (int i = 21; i <= 24; i++) begin
      #1;
      chk("ovf_drain_order", wb_addr, i);
      cycle();
    end
    cycle(); cycle();
    chk("ovf_sticky", ovf_err, 1);

    // asynchronous reset mid-operation
    drv(1, 3, $urandom, 0, 0);
    cycle(); cycle();
    #2;
    do_reset();
    chk("rst_ovf_clear", ovf_err, 0);

    // random phase with occasional resets
    for (int n = 0; n < 600; n++) begin
      if (n % 200 == 199) do_reset();
      drv($urandom_range(0, 1) == 1, 5'($urandom), $urandom,
          $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
